vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator with a pixel-fetch interface for frame-buffer RAM.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_sync_counter.sv | 92 +++++++++
 rtl/vga_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Default timing is 640x480@60 with a 4-clock pixel period.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Deepest read latency the alignment pipeline is meant to cover.
  localparam int RD_LATENCY_MAX = 7;

  // Per-strobe control bits carried alongside the RAM read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_ctl_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider, H/V raster counters, region decode and
// frame/line start pulses. Decode outputs are combinational from the
// counters; the pulses are registered on the strobe that sees (0,0).
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int XW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int YW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_en,
  output logic [XW-1:0] hcount,
  output logic [YW-1:0] vcount,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = cnt_width(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  // Thresholds held one bit wider so a zero back porch cannot overflow.
  localparam logic [XW:0] H_ACT_END = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_BEG    = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END    = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] V_ACT_END = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_BEG    = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END    = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;

  // With CLK_DIV=1 the divider never leaves 0, so the strobe is constant.
  assign pix_en = (div == DIV_LAST);

  // Pixel divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clock) begin
    if (reset)       div <= '0;
    else if (pix_en) div <= '0;
    else             div <= div + 1'b1;
  end

  // Raster counters: vcount steps on every hcount wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // Region decode for the current raster position.
  always_comb begin
    active = ({1'b0, hcount} < H_ACT_END) && ({1'b0, vcount} < V_ACT_END);
    hs     = ({1'b0, hcount} >= HS_BEG) && ({1'b0, hcount} < HS_END);
    vs     = ({1'b0, vcount} >= VS_BEG) && ({1'b0, vcount} < VS_END);
  end

  // Start pulses, one clock wide, raised on the strobe that sees the origin.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      line_start  <= pix_en && (hcount == '0);
      frame_start <= pix_en && (hcount == '0) && (vcount == '0);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with frame-buffer fetch port.
// Fetch coordinates go out on each active strobe; sync and blanking are
// delayed RD_LATENCY strobes so they line up with the returned pixel data.
// RD_LATENCY must lie in 1..RD_LATENCY_MAX.
// Optional: define VGA_TEST_PATTERN_EN to add pattern_sel and the
// built-in test patterns (bars need H_ACTIVE >= 8).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 1,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int RD_LATENCY = 1,
  localparam int XW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 fetch_valid,
  output logic [XW-1:0]        fetch_x,
  output logic [YW-1:0]        fetch_y,
`ifdef VGA_TEST_PATTERN_EN
  input  logic [1:0]           pattern_sel,
`endif
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam logic HS_ON = H_POL[0];
  localparam logic VS_ON = V_POL[0];

  logic          pix_en;
  logic [XW-1:0] hcount;
  logic [YW-1:0] vcount;
  vga_ctl_t      cur;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .XW(XW), .YW(YW)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .active     (cur.active),
    .hs         (cur.hs),
    .vs         (cur.vs),
    .frame_start(frame_start),
    .line_start (line_start)
  );

  // Fetch request: coordinates hold between requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else begin
      fetch_valid <= pix_en && cur.active;
      if (pix_en && cur.active) begin
        fetch_x <= hcount;
        fetch_y <= vcount;
      end
    end
  end

  // Alignment pipeline: control bits travel with the outstanding read.
  vga_ctl_t [RD_LATENCY-1:0] ctl_pipe;
  vga_ctl_t                  dly;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_pipe <= '0;
    end else if (pix_en) begin
      ctl_pipe[0] <= cur;
      for (int i = 1; i < RD_LATENCY; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign dly = ctl_pipe[RD_LATENCY-1];

  logic [3*COLOR_W-1:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

  logic [RD_LATENCY-1:0][XW-1:0] x_pipe;
  logic [RD_LATENCY-1:0][YW-1:0] y_pipe;
  logic [XW-1:0]                 dx, bar_q;
  logic [YW-1:0]                 dy;
  logic [2:0]                    bar;
  logic                          edge_px;

  // Delayed coordinates so patterns share the pass-through timing.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_pipe <= '0;
      y_pipe <= '0;
    end else if (pix_en) begin
      x_pipe[0] <= hcount;
      y_pipe[0] <= vcount;
      for (int i = 1; i < RD_LATENCY; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
      end
    end
  end

  assign dx = x_pipe[RD_LATENCY-1];
  assign dy = y_pipe[RD_LATENCY-1];

  // Pattern select; the last bar absorbs any remainder columns.
  always_comb begin
    bar_q   = dx / XW'(BAR_W);
    bar     = (bar_q > XW'(7)) ? 3'd7 : bar_q[2:0];
    edge_px = (dx == '0) || (dx == XW'(H_ACTIVE - 1)) ||
              (dy == '0) || (dy == YW'(V_ACTIVE - 1));
    case (pattern_sel)
      2'd1:    pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
      2'd2:    pix = edge_px ? '1 : '0;
      2'd3:    pix = '1;
      default: pix = rd_data;
    endcase
  end
`else
  assign pix = rd_data;
`endif

  // Output register: updates only on strobes, blanked outside active.
  always_ff @(posedge clock) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
    end else if (pix_en) begin
      {red, green, blue} <= dly.active ? pix : '0;
      hsync <= dly.hs ? HS_ON : ~HS_ON;
      vsync <= dly.vs ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small timing configurations run side by
// side from one clock and reset. Expected outputs come from the raster
// arithmetic (strobe index -> position -> region) and a queued RAM model.
module tb_vga_timing_gen;

  // Config 0: tiny 8/2/2/2 x 4/1/1/1, CLK_DIV 2, latency 3, low-true syncs.
  // Config 1: 16/3/4/5 x 6/2/2/3, CLK_DIV 1, latency 1, high-true syncs.
  localparam int CWA  [2] = '{2, 1};
  localparam int CDIV [2] = '{2, 1};
  localparam int HAA  [2] = '{8, 16};
  localparam int HFA  [2] = '{2, 3};
  localparam int HSA  [2] = '{2, 4};
  localparam int HBA  [2] = '{2, 5};
  localparam int VAA  [2] = '{4, 6};
  localparam int VFA  [2] = '{1, 2};
  localparam int VSA  [2] = '{1, 2};
  localparam int VBA  [2] = '{1, 3};
  localparam int HPA  [2] = '{0, 1};
  localparam int VPA  [2] = '{0, 1};
  localparam int LATA [2] = '{3, 1};
  // Hand-computed periods in clocks: frame, line, hsync pulse width.
  localparam int FRAME_CLK [2] = '{196, 364};
  localparam int LINE_CLK  [2] = '{28, 28};
  localparam int HSW_CLK   [2] = '{4, 4};

  typedef struct { int due; int x; int y; } req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] psel = 2'd0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int CW = CWA[c];
    localparam int D  = CDIV[c];
    localparam int HA = HAA[c], HF = HFA[c], HS = HSA[c], HB = HBA[c];
    localparam int VA = VAA[c], VF = VFA[c], VS = VSA[c], VB = VBA[c];
    localparam int L  = LATA[c];
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam bit HPB = (HPA[c] != 0);
    localparam bit VPB = (VPA[c] != 0);

    logic          fv, fs, ls, hs, vs;
    logic [XW-1:0] fx;
    logic [YW-1:0] fy;
    logic [3*CW-1:0] rd = '0;
    logic [CW-1:0] r, g, b;

    vga_timing_gen #(
      .COLOR_W(CW), .CLK_DIV(D),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(HPA[c]), .V_POL(VPA[c]), .RD_LATENCY(L)
    ) dut (
      .clock(clk), .reset(rst),
      .fetch_valid(fv), .fetch_x(fx), .fetch_y(fy),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .rd_data(rd), .red(r), .green(g), .blue(b),
      .hsync(hs), .vsync(vs), .frame_start(fs), .line_start(ls)
    );

    // Frame-buffer contents as a function of the pixel position.
    function automatic logic [3*CW-1:0] ram(input int x, input int y);
      return (3*CW)'(x * 5 + y * 3 + 1 + c);
    endfunction

    // Expected colour of a visible pixel for a given pattern selection.
    function automatic logic [3*CW-1:0] exp_rgb(input int x, input int y, input int sel);
      int k;
      case (sel)
        1: begin
          k = x / (HA / 8);
          if (k > 7) k = 7;
          return {{CW{k[2]}}, {CW{k[1]}}, {CW{k[0]}}};
        end
        2: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? '1 : '0;
        3: return '1;
        default: return ram(x, y);
      endcase
    endfunction

    // Clocks since reset release (0 while reset is sampled high).
    int p = 0;
    always @(posedge clk) p <= rst ? 0 : p + 1;

    // RAM: answers each fetch exactly L strobes later, noise otherwise.
    req_t q[$];
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        rd = (3*CW)'($urandom);
      end else begin
        if (fv) q.push_back('{p + L * D, int'(fx), int'(fy)});
        if (q.size() > 0 && q[0].due == p + 1) begin
          rd = ram(q[0].x, q[0].y);
          void'(q.pop_front());
        end else begin
          rd = (3*CW)'($urandom);
        end
      end
    end

    int lf = -1, ll = -1, hw = -1, nfp = 0;

    // Compare every clock against the raster model.
    always @(negedge clk) begin
      int k, j, h, v;
      bit st, e_fs, e_ls, e_fv, e_hs, e_vs;
      logic [3*CW-1:0] e_rgb;
      st = (p >= D) && (p % D == 0);
      k = p / D - 1;
      e_fs = 1'b0; e_ls = 1'b0; e_fv = 1'b0; h = 0; v = 0;
      if (st) begin
        h = k % HT; v = (k / HT) % VT;
        e_ls = (h == 0);
        e_fs = (h == 0) && (v == 0);
        e_fv = (h < HA) && (v < VA);
      end
      chk($sformatf("c%0d frame_start", c), int'(fs), int'(e_fs));
      chk($sformatf("c%0d line_start", c), int'(ls), int'(e_ls));
      chk($sformatf("c%0d fetch_valid", c), int'(fv), int'(e_fv));
      if (e_fv) begin
        chk($sformatf("c%0d fetch_x", c), int'(fx), h);
        chk($sformatf("c%0d fetch_y", c), int'(fy), v);
      end
      j = k - L;
      e_hs = !HPB; e_vs = !VPB; e_rgb = '0;
      if (j >= 0) begin
        h = j % HT; v = (j / HT) % VT;
        if (h >= HA + HF && h < HA + HF + HS) e_hs = HPB;
        if (v >= VA + VF && v < VA + VF + VS) e_vs = VPB;
        if (h < HA && v < VA) e_rgb = exp_rgb(h, v, int'(psel));
      end
      chk($sformatf("c%0d hsync", c), int'(hs), int'(e_hs));
      chk($sformatf("c%0d vsync", c), int'(vs), int'(e_vs));
      chk($sformatf("c%0d rgb", c), int'({r, g, b}), int'(e_rgb));

      // Literal period / width measurements on the DUT pins.
      if (rst) begin
        lf = -1; ll = -1; hw = -1;
      end else begin
        if (fs) begin
          if (lf >= 0) begin
            chk($sformatf("c%0d frame period", c), p - lf, FRAME_CLK[c]);
            nfp++;
          end
          lf = p;
        end
        if (ls) begin
          if (ll >= 0) chk($sformatf("c%0d line period", c), p - ll, LINE_CLK[c]);
          ll = p;
        end
        if (hs == HPB) begin
          if (hw >= 0) hw++;
        end else begin
          if (hw > 0) chk($sformatf("c%0d hsync width", c), hw, HSW_CLK[c]);
          hw = 0;
        end
      end
    end
  end

  // Stimulus: long first run, then random-length runs ended by 5-clock resets.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (1500) @(posedge clk);
    for (int ph = 0; ph < 8; ph++) begin
      #1 rst = 1'b1;
      @(posedge clk);
`ifdef VGA_TEST_PATTERN_EN
      #1 psel = 2'($urandom_range(0, 3));
`endif
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat ($urandom_range(400, 1200)) @(posedge clk);
    end
    #1;
    chk("c0 frame periods seen", int'(g_cfg[0].nfp > 0), 1);
    chk("c1 frame periods seen", int'(g_cfg[1].nfp > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
